// File: rtl/fas_pkg.sv
// fas_pkg: shared FFT word, magnitude and analyzer state types for FAS.
package fas_pkg;
  localparam int FFT_NPOINT = 16;
  localparam int FFT_DW = 16;
  localparam int FFT_MW = 32;
  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } fft_word_t;
  typedef logic [FFT_MW-1:0] fft_mag_t;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
endpackage

// File: rtl/fft_freq_analyzer_if.sv
// fft_freq_analyzer_if: FFT frame input and peak report outputs; peak_mag exists only with FAS_PEAK_MAG_EN.
interface fft_freq_analyzer_if;
  import fas_pkg::*;
  logic fft_valid;
  fft_word_t fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  fft_word_t fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic done;
  logic [3:0] freq;
  logic busy;
  logic overflow;
`ifdef FAS_PEAK_MAG_EN
  fft_mag_t peak_mag;
`endif
  modport slave (
    input fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
          fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, busy, overflow
`ifdef FAS_PEAK_MAG_EN
    , peak_mag
`endif
  );
  modport master (
    output fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input done, freq, busy, overflow
`ifdef FAS_PEAK_MAG_EN
    , peak_mag
`endif
  );
endinterface

// File: rtl/fas_mag_sq.sv
// fas_mag_sq: combinational re^2 + im^2 of one complex FFT word.
module fas_mag_sq
  import fas_pkg::*;
(
  input  fft_word_t w,
  output fft_mag_t  mag
);
  logic signed [2*FFT_DW-1:0] rr, ii;
  assign rr = (2*FFT_DW)'(w.re) * (2*FFT_DW)'(w.re);
  assign ii = (2*FFT_DW)'(w.im) * (2*FFT_DW)'(w.im);
  assign mag = fft_mag_t'(rr) + fft_mag_t'(ii);
endmodule

// File: rtl/fft_freq_analyzer.sv
// fft_freq_analyzer: double-buffered peak-bin finder over 16-point FFT frames; FAS_PEAK_MAG_EN adds peak_mag.
module fft_freq_analyzer
  import fas_pkg::*;
(
  input logic clk,
  input logic rst,
  fft_freq_analyzer_if.slave bus
);
  fft_word_t fin [FFT_NPOINT];
  fft_word_t act [FFT_NPOINT];
  fft_word_t pend [FFT_NPOINT];
  state_t state, nxt;
  logic pend_full, move, load_act, load_pend, drop, done, overflow;
  logic [3:0] idx, maxidx, freq;
  fft_mag_t mx, mag;
`ifdef FAS_PEAK_MAG_EN
  fft_mag_t peak_mag;
  assign bus.peak_mag = peak_mag;
`endif
  assign fin[0] = bus.fft_d0;
  assign fin[1] = bus.fft_d1;
  assign fin[2] = bus.fft_d2;
  assign fin[3] = bus.fft_d3;
  assign fin[4] = bus.fft_d4;
  assign fin[5] = bus.fft_d5;
  assign fin[6] = bus.fft_d6;
  assign fin[7] = bus.fft_d7;
  assign fin[8] = bus.fft_d8;
  assign fin[9] = bus.fft_d9;
  assign fin[10] = bus.fft_d10;
  assign fin[11] = bus.fft_d11;
  assign fin[12] = bus.fft_d12;
  assign fin[13] = bus.fft_d13;
  assign fin[14] = bus.fft_d14;
  assign fin[15] = bus.fft_d15;
  assign bus.done = done;
  assign bus.freq = freq;
  assign bus.overflow = overflow;
  assign bus.busy = (state != IDLE) || pend_full;
  // A frame arriving while PENDING is handed over in REPORT refills PENDING
  assign move = (state == REPORT) && pend_full;
  assign load_act = bus.fft_valid && (state == IDLE);
  assign load_pend = bus.fft_valid && (state != IDLE) && (!pend_full || move);
  assign drop = bus.fft_valid && (state != IDLE) && pend_full && !move;
  fas_mag_sq u_mag (.w(act[idx]), .mag(mag));
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (bus.fft_valid ? SCAN : IDLE) :
          (state == SCAN) ? ((idx == 4'd15) ? REPORT : SCAN) :
          (pend_full ? SCAN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (load_act) act <= fin;
    else if (move) act <= pend;
    if (load_pend) pend <= fin;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      idx <= '0;
      maxidx <= '0;
      mx <= '0;
      done <= 1'b0;
      freq <= '0;
      overflow <= 1'b0;
`ifdef FAS_PEAK_MAG_EN
      peak_mag <= '0;
`endif
    end else begin
      done <= (state == REPORT);
      pend_full <= load_pend || (pend_full && !move);
      overflow <= overflow || drop;
      if (state == REPORT) begin
        freq <= maxidx;
`ifdef FAS_PEAK_MAG_EN
        peak_mag <= mx;
`endif
      end
      // Strict compare keeps the lowest index on ties; idx 0 seeds the max
      if (state == SCAN) begin
        idx <= idx + 4'd1;
        if (idx == 4'd0 || mag > mx) begin
          mx <= mag;
          maxidx <= idx;
        end
      end
    end
  end
endmodule
